switch_loader: RTL

SWITCH_LOADER -- requirements
Module: switch_loader

---
 rtl/switch_loader.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/switch_loader.sv
// switch_loader: loads a DATA_W operand a byte at a time from the slide
// switches, captures a control word, and issues single-cycle step pulses
// from debounced or synchronized push-buttons.
// Optional feature macro: INPUT_LOADER_DEBOUNCE_EN. When it is defined, each
// synchronized key level must be stable for DB_CYC cycles before it is used.
//
// state | meaning
// IDLE  | waiting for a STEP or LOAD press
// STEP  | one-cycle step pulse being issued
// HOLD  | waiting for STEP key release; all presses dropped
module switch_loader #(
  parameter int DATA_W = 16,
  parameter int CTRL_W = 9,
  parameter int DB_CYC = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [9:0]        sw,
  input  logic [1:0]        key_n,
  output logic [DATA_W-1:0] datapath_in,
  output logic [CTRL_W-1:0] ctrl,
  output logic              step,
  output logic [2:0]        byte_ptr,
  output logic              busy,
  output logic [9:0]        ledr
);

  localparam int NB = DATA_W / 8;

  if ((DATA_W % 8) != 0 || DATA_W < 8 || DATA_W > 64 ||
      CTRL_W < 1 || CTRL_W > 9 || DB_CYC < 1) begin : g_bad_param
    $error("switch_loader: parameter out of range");
  end

  typedef enum logic [1:0] {S_IDLE, S_STEP, S_HOLD} state_t;

  state_t              state_q, state_d;
  logic [1:0]          key_s1_q, key_s2_q;
  logic [1:0]          key_lvl;
  logic [1:0]          key_prev_q;
  logic [1:0]          press;
  logic                load_ok;
  logic [DATA_W-1:0]   stage_q, stage_d;
  logic [DATA_W-1:0]   dp_q, dp_d;
  logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
  logic [2:0]          ptr_q, ptr_d;
  logic                step_q;
  logic [2:0]          led_idx;
  logic [7:0]          led_byte;
  logic [9:0]          led_ctrl;

  // Two-flop synchronizer; released (high) out of reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      key_s1_q <= 2'b11;
      key_s2_q <= 2'b11;
    end else begin
      key_s1_q <= key_n;
      key_s2_q <= key_s1_q;
    end
  end

`ifdef INPUT_LOADER_DEBOUNCE_EN
  localparam int DBW = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;
  localparam logic [DBW-1:0] DB_RELOAD = DBW'(DB_CYC - 1);

  logic [1:0]           key_acc_q;
  logic [1:0][DBW-1:0]  db_cnt_q;

  // Down-counter per key; a new level is accepted when it survives DB_CYC samples.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!reset_n) begin
        key_acc_q[i] <= 1'b1;
        db_cnt_q[i]  <= DB_RELOAD;
      end else if (key_s2_q[i] == key_acc_q[i]) begin
        db_cnt_q[i]  <= DB_RELOAD;
      end else if (db_cnt_q[i] == '0) begin
        key_acc_q[i] <= key_s2_q[i];
        db_cnt_q[i]  <= DB_RELOAD;
      end else begin
        db_cnt_q[i]  <= db_cnt_q[i] - 1'b1;
      end
    end
  end

  assign key_lvl = key_acc_q;
`else
  assign key_lvl = key_s2_q;
`endif

  // Previous level for falling-edge (press) detection.
  always_ff @(posedge clk) begin
    if (!reset_n) key_prev_q <= 2'b11;
    else          key_prev_q <= key_lvl;
  end

  assign press = key_prev_q & ~key_lvl;

  // Next-state logic; STEP wins over LOAD, presses outside IDLE are dropped.
  always_comb begin
    state_d = state_q;
    load_ok = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (press[0])      state_d = S_STEP;
        else if (press[1]) load_ok = 1'b1;
      end
      S_STEP: state_d = S_HOLD;
      S_HOLD: if (key_lvl[0]) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Staging write, commit on the last byte, or control capture.
  always_comb begin
    stage_d = stage_q;
    dp_d    = dp_q;
    ctrl_d  = ctrl_q;
    ptr_d   = ptr_q;
    if (load_ok) begin
      if (sw[9]) begin
        for (int b = 0; b < NB; b++) begin
          if (ptr_q == 3'(b)) stage_d[b*8 +: 8] = sw[7:0];
        end
        if (ptr_q == 3'(NB - 1)) begin
          dp_d  = stage_d;
          ptr_d = 3'd0;
        end else begin
          ptr_d = ptr_q + 3'd1;
        end
      end else begin
        ctrl_d = sw[CTRL_W-1:0];
      end
    end
  end

  // State and datapath registers; reset overrides any pending transition.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      stage_q <= '0;
      dp_q    <= '0;
      ctrl_q  <= '0;
      ptr_q   <= 3'd0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      dp_q    <= dp_d;
      ctrl_q  <= ctrl_d;
      ptr_q   <= ptr_d;
      step_q  <= (state_d == S_STEP);
    end
  end

  // Status display: last written staging byte or the control word.
  always_comb begin
    led_idx  = (ptr_q == 3'd0) ? 3'(NB - 1) : ptr_q - 3'd1;
    led_byte = 8'h00;
    for (int b = 0; b < NB; b++) begin
      if (led_idx == 3'(b)) led_byte = stage_q[b*8 +: 8];
    end
    led_ctrl = '0;
    led_ctrl[CTRL_W-1:0] = ctrl_q;
  end

  assign ledr        = sw[9] ? {ptr_q[1:0], led_byte} : led_ctrl;
  assign datapath_in = dp_q;
  assign ctrl        = ctrl_q;
  assign step        = step_q;
  assign byte_ptr    = ptr_q;
  assign busy        = (state_q != S_IDLE);

endmodule
